// File: rtl/fifo_ptr_pkg.sv
// Shared pointer types and comparison helpers for the async FIFO pointer controllers.
package fifo_ptr_pkg;

  localparam int PTR_WIDTH  = 8;
  localparam int ADDR_WIDTH = PTR_WIDTH - 1;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [PTR_WIDTH-1:0]  ptr_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  // Full when the write Gray pointer is a whole lap ahead: top two bits inverted, rest equal.
  function automatic logic full_cmp(input ptr_t gray_next, input ptr_t rd_gray_sync);
    return gray_next == {~rd_gray_sync[PTR_WIDTH-1 -: 2], rd_gray_sync[PTR_WIDTH-3:0]};
  endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary to reflected-Gray conversion.
module bin_to_gray #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_to_bin.sv
// Combinational reflected-Gray to binary conversion (prefix XOR from the MSB down).
module gray_to_bin #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    bin_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer controller of the async FIFO: binary/Gray write pointer, RAM strobe,
// read-pointer synchroniser and registered full flag. Almost-full needs ASYNC_FIFO_AFULL_EN.
module async_fifo_wr_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int CNTR_WIDTH   = PTR_WIDTH,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic                  wr_en_o,
  output logic [CNTR_WIDTH-2:0] wr_addr_o,
  output logic [CNTR_WIDTH-1:0] wr_bin_ptr_o,
  output logic [CNTR_WIDTH-1:0] wr_gray_ptr_o,
  input  logic [CNTR_WIDTH-1:0] rd_gray_ptr_i,
  output logic                  full_o,
  output logic                  almost_full_o
);

  if (SYNC_STAGES < 2 || AFULL_THRESH < 0 || AFULL_THRESH >= 2 ** (CNTR_WIDTH - 1))
  begin : g_bad_params
    $error("async_fifo_wr_ctrl: illegal SYNC_STAGES or AFULL_THRESH");
  end

  logic [CNTR_WIDTH-1:0] wr_bin_q, wr_bin_d;
  logic [CNTR_WIDTH-1:0] wr_gray_q, wr_gray_d;
  logic [CNTR_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CNTR_WIDTH-1:0] sync_d [SYNC_STAGES];
  logic                  full_q, full_d;
  logic                  afull_q, afull_d;
  logic                  push;
  logic [CNTR_WIDTH-1:0] bin_next;
  logic [CNTR_WIDTH-1:0] gray_next;
  logic [CNTR_WIDTH-1:0] rd_gray_sync;

  assign push         = wr_valid_i & ~full_q;
  assign bin_next     = wr_bin_q + {{(CNTR_WIDTH-1){1'b0}}, push};
  assign rd_gray_sync = sync_q[SYNC_STAGES-1];

  bin_to_gray #(.WIDTH(CNTR_WIDTH)) u_bin_to_gray (
    .bin_i  (bin_next),
    .gray_o (gray_next)
  );

`ifdef ASYNC_FIFO_AFULL_EN
  localparam logic [CNTR_WIDTH-1:0] AFULL_LEVEL =
    CNTR_WIDTH'(2 ** (CNTR_WIDTH - 1) - AFULL_THRESH);

  logic [CNTR_WIDTH-1:0] rd_bin_sync;
  logic [CNTR_WIDTH-1:0] count_next;

  gray_to_bin #(.WIDTH(CNTR_WIDTH)) u_gray_to_bin (
    .gray_i (rd_gray_sync),
    .bin_o  (rd_bin_sync)
  );

  assign count_next = bin_next - rd_bin_sync;
  assign afull_d    = (count_next >= AFULL_LEVEL);
`else
  assign afull_d = 1'b0;
`endif

  // Next-state values for pointers, full flag and the synchroniser chain.
  always_comb begin
    wr_bin_d  = bin_next;
    wr_gray_d = gray_next;
    full_d    = full_cmp(gray_next, rd_gray_sync);
    sync_d[0] = rd_gray_ptr_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // All write-domain state, cleared together by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign wr_ready_o    = ~full_q;
  assign wr_en_o       = push & ~reset;
  assign wr_addr_o     = wr_bin_q[CNTR_WIDTH-2:0];
  assign wr_bin_ptr_o  = wr_bin_q;
  assign wr_gray_ptr_o = wr_gray_q;
  assign full_o        = full_q;
  assign almost_full_o = afull_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Self-checking bench for async_fifo_wr_ctrl: vector table, directed corners, random traffic.
module tb_async_fifo_wr_ctrl;

  localparam int W     = 8;
  localparam int SYNC  = 2;
  localparam int DEPTH = 128;
  localparam int AF    = 4;
`ifdef ASYNC_FIFO_AFULL_EN
  localparam bit AFULL_EN = 1'b1;
`else
  localparam bit AFULL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_valid_i;
  logic         wr_ready_o;
  logic         wr_en_o;
  logic [W-2:0] wr_addr_o;
  logic [W-1:0] wr_bin_ptr_o;
  logic [W-1:0] wr_gray_ptr_o;
  logic [W-1:0] rd_gray_ptr_i;
  logic         full_o;
  logic         almost_full_o;

  async_fifo_wr_ctrl #(.CNTR_WIDTH(W), .SYNC_STAGES(SYNC), .AFULL_THRESH(AF)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_valid_i    (wr_valid_i),
    .wr_ready_o    (wr_ready_o),
    .wr_en_o       (wr_en_o),
    .wr_addr_o     (wr_addr_o),
    .wr_bin_ptr_o  (wr_bin_ptr_o),
    .wr_gray_ptr_o (wr_gray_ptr_o),
    .rd_gray_ptr_i (rd_gray_ptr_i),
    .full_o        (full_o),
    .almost_full_o (almost_full_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: counts of writes and reads, plus reads as seen after synchronisation.
  int wr_cnt = 0;
  int rd_cnt = 0;
  int rd_seen [SYNC];
  bit m_full = 1'b0;
  int en_pulses;
  int af_rise_at;
  bit seen_full, bin_wrapped, gray_wrapped;
  logic [W-1:0] prev_bin, prev_gray;

  typedef struct {
    bit           rst;
    bit           v;
    bit           exp_en;
    logic [W-2:0] exp_addr;
    logic [W-1:0] exp_bin;
    logic [W-1:0] exp_gray;
  } vec_t;
  vec_t vecs [8];

  function automatic logic [W-1:0] to_gray(input int b);
    logic [W-1:0] x;
    x = b[W-1:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus, checked against the counting model before and after the edge.
  task automatic cycle(input bit rst, input bit v);
    bit push;
    int occ;
    reset         = rst;
    wr_valid_i    = v;
    rd_gray_ptr_i = to_gray(rd_cnt);
    #1;
    push = v && !m_full && !rst;
    chk("wr_en", wr_en_o, push);
    chk("wr_ready", wr_ready_o, !m_full);
    if (push) chk("wr_addr", wr_addr_o, wr_cnt % DEPTH);
    if (wr_en_o === 1'b1) en_pulses++;
    prev_bin  = wr_bin_ptr_o;
    prev_gray = wr_gray_ptr_o;
    @(posedge clk);
    #1;
    if (rst) begin
      wr_cnt = 0;
      m_full = 1'b0;
      occ    = 0;
      for (int i = 0; i < SYNC; i++) rd_seen[i] = 0;
    end else begin
      wr_cnt = (wr_cnt + (push ? 1 : 0)) % 256;
      occ    = (wr_cnt - rd_seen[SYNC-1] + 256) % 256;
      m_full = (occ == DEPTH);
      for (int i = SYNC - 1; i > 0; i--) rd_seen[i] = rd_seen[i-1];
      rd_seen[0] = rd_cnt;
    end
    chk("bin_ptr", wr_bin_ptr_o, wr_cnt);
    chk("gray_ptr", wr_gray_ptr_o, to_gray(wr_cnt));
    chk("full", full_o, m_full);
    chk("almost_full", almost_full_o, AFULL_EN && !rst && occ >= DEPTH - AF);
    if (!rst && wr_gray_ptr_o !== prev_gray)
      chk("gray_one_bit", $countones(wr_gray_ptr_o ^ prev_gray), 1);
    if (full_o === 1'b1) seen_full = 1'b1;
    if (almost_full_o === 1'b1 && af_rise_at < 0) af_rise_at = wr_bin_ptr_o;
    if (prev_bin == 8'hFF && wr_bin_ptr_o == 8'h00) bin_wrapped = 1'b1;
    if (prev_gray == 8'h80 && wr_gray_ptr_o == 8'h00) gray_wrapped = 1'b1;
  endtask

  task automatic restart();
    rd_cnt     = 0;
    en_pulses  = 0;
    af_rise_at = -1;
    seen_full  = 1'b0;
    cycle(1'b1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < SYNC; i++) rd_seen[i] = 0;
    reset         = 1'b1;
    wr_valid_i    = 1'b0;
    rd_gray_ptr_i = 8'h00;

    // {rst, valid, wr_en, addr, bin after edge, gray after edge}
    vecs[0] = '{1'b1, 1'b1, 1'b0, 7'd0, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 7'd0, 8'h01, 8'h01};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 7'd1, 8'h01, 8'h01};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 7'd1, 8'h02, 8'h03};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 7'd2, 8'h03, 8'h02};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 7'd3, 8'h00, 8'h00};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 7'd0, 8'h01, 8'h01};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 7'd1, 8'h02, 8'h03};

    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      reset      = vecs[i].rst;
      wr_valid_i = vecs[i].v;
      #1;
      chk("vec_wr_en", wr_en_o, vecs[i].exp_en);
      if (!vecs[i].rst) chk("vec_addr", wr_addr_o, vecs[i].exp_addr);
      @(posedge clk);
      #1;
      chk("vec_bin", wr_bin_ptr_o, vecs[i].exp_bin);
      chk("vec_gray", wr_gray_ptr_o, vecs[i].exp_gray);
      chk("vec_full", full_o, 1'b0);
    end

    // Fill with the reader stalled at 0.
    restart();
    for (int i = 0; i < 130; i++) cycle(1'b0, 1'b1);
    chk("fill_pulses", en_pulses, DEPTH);
    chk("fill_full", full_o, 1'b1);
    chk("fill_bin", wr_bin_ptr_o, 8'h80);
    chk("fill_gray", wr_gray_ptr_o, 8'hC0);
    chk("afull_rise_push", af_rise_at, AFULL_EN ? DEPTH - AF : -1);

    // One read frees one slot within SYNC_STAGES+1 edges.
    rd_cnt = 1;
    for (int i = 0; i < SYNC + 1; i++) cycle(1'b0, 1'b0);
    chk("full_release", full_o, 1'b0);
    en_pulses = 0;
    cycle(1'b0, 1'b1);
    chk("refill_pulse", en_pulses, 1);
    chk("refill_full", full_o, 1'b1);
    cycle(1'b0, 1'b1);
    chk("refill_held", wr_bin_ptr_o, 8'h81);

    // Reader keeps pace: pointer wraps, full never seen.
    restart();
    bin_wrapped  = 1'b0;
    gray_wrapped = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cycle(1'b0, 1'b1);
      rd_cnt = wr_cnt;
    end
    chk("pace_no_full", seen_full, 1'b0);
    chk("pace_bin_wrap", bin_wrapped, 1'b1);
    chk("pace_gray_wrap", gray_wrapped, 1'b1);

    // Random push/idle traffic with a slower, bursty reader.
    restart();
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)));
      if (rd_cnt != wr_cnt && $urandom_range(0, 2) == 0) rd_cnt = (rd_cnt + 1) % 256;
    end

    // Reset in the middle of traffic.
    restart();
    for (int i = 0; i < 50; i++) cycle(1'b0, 1'b1);
    chk("pre_reset_bin", wr_bin_ptr_o, 8'd50);
    rd_cnt = 0;
    cycle(1'b1, 1'b1);
    chk("rst_bin", wr_bin_ptr_o, 8'h00);
    chk("rst_gray", wr_gray_ptr_o, 8'h00);
    chk("rst_full", full_o, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_wr_en", wr_en_o, 1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    chk("post_rst_bin", wr_bin_ptr_o, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
